// File: rtl/bg_pixel_pkg.sv
// Shared constants, width helpers and pixel layout for the background pixel pipeline.
package bg_pixel_pkg;

  localparam int DEF_TILE_W = 8;
  localparam int DEF_PLANES = 2;
  localparam int DEF_ATTR_W = 2;

  function automatic int fine_width(input int tile_w);
    return (tile_w > 1) ? $clog2(tile_w) : 1;
  endfunction

  function automatic int sel_width(input int planes);
    return (planes > 1) ? $clog2(planes) : 1;
  endfunction

  typedef struct packed {
    logic                  bg_sel;
    logic [DEF_ATTR_W-1:0] attr;
    logic [DEF_PLANES-1:0] planes;
  } bg_pixel_t;

endpackage

// File: rtl/bg_tile_shifter_pipe_if.sv
// Fetch-side bus carrying pattern-plane and attribute writes into the background pipeline.
interface bg_tile_shifter_pipe_if
  import bg_pixel_pkg::*;
#(
  parameter int TILE_W = DEF_TILE_W,
  parameter int PLANES = DEF_PLANES,
  parameter int ATTR_W = DEF_ATTR_W
);
  localparam int SEL_W = sel_width(PLANES);

  logic              plane_valid;
  logic [SEL_W-1:0]  plane_sel;
  logic [TILE_W-1:0] plane_data;
  logic              attr_valid;
  logic [ATTR_W-1:0] attr_data;

  modport master (
    output plane_valid, plane_sel, plane_data, attr_valid, attr_data
  );

  modport slave (
    input plane_valid, plane_sel, plane_data, attr_valid, attr_data
  );
endinterface

// File: rtl/bg_plane_shifter.sv
// One 2*TILE_W background shifter with its staging register, staged flag and fine-scroll tap.
module bg_plane_shifter
  import bg_pixel_pkg::*;
#(
  parameter  int TILE_W = DEF_TILE_W,
  localparam int FINE_W = fine_width(TILE_W)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clock_en,
  input  logic              capture,
  input  logic [TILE_W-1:0] capture_data,
  input  logic              shift,
  input  logic              reload,
  input  logic [FINE_W-1:0] fine,
  output logic              tap,
  output logic              staged
);
  logic [2*TILE_W-1:0] shift_r;
  logic [2*TILE_W-1:0] shift_next_s;
  logic [TILE_W-1:0]   stage_r;
  logic [TILE_W-1:0]   upper_s;
  logic                flag_r;

  // Next shifter value: reload refills the lower half (zero when nothing was staged).
  always_comb begin
    shift_next_s = shift_r;
    if (reload) begin
      shift_next_s = {shift_r[2*TILE_W-2:TILE_W-1], flag_r ? stage_r : {TILE_W{1'b0}}};
    end else if (shift) begin
      shift_next_s = {shift_r[2*TILE_W-2:0], 1'b0};
    end else begin
      shift_next_s = shift_r;
    end
  end

  // Shifter, staging and flag state; a capture on the reload tick belongs to the next tile.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_r <= {(2*TILE_W){1'b0}};
      stage_r <= {TILE_W{1'b0}};
      flag_r  <= 1'b0;
    end else if (clock_en) begin
      shift_r <= shift_next_s;
      if (capture) begin
        stage_r <= capture_data;
        flag_r  <= 1'b1;
      end else if (reload) begin
        flag_r  <= 1'b0;
      end
    end
  end

  // ~fine addresses bit TILE_W-1-fine of the upper half, i.e. 2*TILE_W-1-fine overall.
  assign upper_s = shift_r[2*TILE_W-1:TILE_W];
  assign tap     = upper_s[~fine];
  assign staged  = flag_r;
endmodule

// File: rtl/bg_tile_shifter_pipe.sv
// Background pixel pipeline: tile-phase counter, plane/attribute shifters and pixel index output.
// Left-column clipping is built only when BG_LEFT_CLIP_EN is defined.
module bg_tile_shifter_pipe
  import bg_pixel_pkg::*;
#(
  parameter  int TILE_W = DEF_TILE_W,
  parameter  int PLANES = DEF_PLANES,
  parameter  int ATTR_W = DEF_ATTR_W,
  localparam int FINE_W = fine_width(TILE_W),
  localparam int OUT_W  = 1 + ATTR_W + PLANES
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clock_EN,
  input  logic                  enable,
  input  logic                  backgroundDraw_EN,
  input  logic                  line_start,
  bg_tile_shifter_pipe_if.slave fetch,
  input  logic [FINE_W-1:0]     fineScroll,
  input  logic                  clip_left,
  output logic [OUT_W-1:0]      pixelIndex,
  output logic [FINE_W-1:0]     phase,
  output logic                  tile_underrun
);
  localparam int NSH   = PLANES + ATTR_W;
  localparam int SEL_W = sel_width(PLANES);
  localparam logic [FINE_W-1:0] PHASE_LAST = FINE_W'(TILE_W - 1);

  logic [FINE_W-1:0] phase_r;
  logic              underrun_r;
  logic              reload_s;
  logic              shift_s;
  logic              clip_s;
  logic [NSH-1:0]    tap_s;
  logic [NSH-1:0]    staged_s;
  logic [OUT_W-1:0]  pixel_s;

  // line_start wins over the phase wrap, so no reload happens on a line-start tick.
  assign reload_s = enable && !line_start && (phase_r == PHASE_LAST);
  assign shift_s  = enable && !reload_s;

  for (genvar gi = 0; gi < NSH; gi++) begin : g_sh
    logic              cap_g;
    logic [TILE_W-1:0] data_g;
    if (gi < PLANES) begin : g_plane
      assign cap_g  = fetch.plane_valid && (fetch.plane_sel == SEL_W'(gi));
      assign data_g = fetch.plane_data;
    end else begin : g_attr
      assign cap_g  = fetch.attr_valid;
      assign data_g = {TILE_W{fetch.attr_data[gi-PLANES]}};
    end
    bg_plane_shifter #(.TILE_W(TILE_W)) u_shifter (
      .clock        (clock),
      .reset        (reset),
      .clock_en     (clock_EN),
      .capture      (cap_g),
      .capture_data (data_g),
      .shift        (shift_s),
      .reload       (reload_s),
      .fine         (fineScroll),
      .tap          (tap_s[gi]),
      .staged       (staged_s[gi])
    );
  end

  // Tile phase and sticky underrun flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase_r    <= {FINE_W{1'b0}};
      underrun_r <= 1'b0;
    end else if (clock_EN) begin
      if (line_start) begin
        phase_r <= {FINE_W{1'b0}};
      end else if (enable) begin
        phase_r <= phase_r + FINE_W'(1);
      end
      if (reload_s && !(&staged_s)) begin
        underrun_r <= 1'b1;
      end
    end
  end

`ifdef BG_LEFT_CLIP_EN
  localparam logic [FINE_W:0] COL_MAX = (FINE_W+1)'(TILE_W);
  logic [FINE_W:0] column_r;

  // Column counter since line start, saturating once the first tile has passed.
  always_ff @(posedge clock) begin
    if (reset) begin
      column_r <= {(FINE_W+1){1'b0}};
    end else if (clock_EN) begin
      if (line_start) begin
        column_r <= {(FINE_W+1){1'b0}};
      end else if (enable && (column_r != COL_MAX)) begin
        column_r <= column_r + (FINE_W+1)'(1);
      end
    end
  end

  assign clip_s = clip_left && (column_r < COL_MAX);
`else
  logic clip_left_unused_s;
  assign clip_left_unused_s = clip_left;
  assign clip_s             = 1'b0;
`endif

  // Pixel index: taps ordered {attr, planes}; blanked when not rendering, hidden or clipped.
  always_comb begin
    pixel_s = {1'b0, tap_s};
    if (!enable || !backgroundDraw_EN || clip_s) begin
      pixel_s = {OUT_W{1'b0}};
    end else begin
      pixel_s = {1'b0, tap_s};
    end
  end

  assign pixelIndex    = pixel_s;
  assign phase         = phase_r;
  assign tile_underrun = underrun_r;
endmodule

// File: tb/tb_bg_tile_shifter_pipe.sv
// Directed self-checking bench for bg_tile_shifter_pipe with default parameters.
module tb_bg_tile_shifter_pipe;
  import bg_pixel_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       clock_EN;
  logic       enable;
  logic       backgroundDraw_EN;
  logic       line_start;
  logic [2:0] fineScroll;
  logic       clip_left;
  logic [4:0] pixelIndex;
  logic [2:0] phase;
  logic       tile_underrun;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Expected pixel streams at bit 15, derived by hand from the staged tiles.
  logic [7:0] tile1_px [0:7] = '{8'h09, 8'h08, 8'h0B, 8'h0A, 8'h0A, 8'h0B, 8'h08, 8'h09};
  logic [7:0] tile3_px [0:7] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] tile4_px [0:7] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02};

  bg_tile_shifter_pipe_if #(.TILE_W(8), .PLANES(2), .ATTR_W(2)) fetch_if ();

  bg_tile_shifter_pipe dut (
    .clock             (clock),
    .reset             (reset),
    .clock_EN          (clock_EN),
    .enable            (enable),
    .backgroundDraw_EN (backgroundDraw_EN),
    .line_start        (line_start),
    .fetch             (fetch_if),
    .fineScroll        (fineScroll),
    .clip_left         (clip_left),
    .pixelIndex        (pixelIndex),
    .phase             (phase),
    .tile_underrun     (tile_underrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_fetch();
    fetch_if.plane_valid = 1'b0;
    fetch_if.plane_sel   = 1'b0;
    fetch_if.plane_data  = 8'h00;
    fetch_if.attr_valid  = 1'b0;
    fetch_if.attr_data   = 2'd0;
  endtask

  task automatic do_reset();
    reset             = 1'b1;
    clock_EN          = 1'b1;
    enable            = 1'b0;
    backgroundDraw_EN = 1'b1;
    line_start        = 1'b0;
    clip_left         = 1'b0;
    fineScroll        = 3'd0;
    clear_fetch();
    tick();
    tick();
    reset = 1'b0;
    check("rst_pixel", 8'(pixelIndex), 8'h00);
    check("rst_phase", 8'(phase), 8'h00);
    check("rst_underrun", 8'(tile_underrun), 8'h00);
  endtask

  task automatic drive_n(input int n);
    clear_fetch();
    case (n)
      1:  begin fetch_if.plane_valid = 1'b1; fetch_if.plane_sel = 1'b0; fetch_if.plane_data = 8'hA5; end
      2:  begin fetch_if.plane_valid = 1'b1; fetch_if.plane_sel = 1'b1; fetch_if.plane_data = 8'h3C; end
      3:  begin fetch_if.attr_valid = 1'b1; fetch_if.attr_data = 2'd2; end
      9:  begin fetch_if.plane_valid = 1'b1; fetch_if.plane_sel = 1'b0; fetch_if.plane_data = 8'hFF; end
      10: begin fetch_if.plane_valid = 1'b1; fetch_if.plane_sel = 1'b1; fetch_if.plane_data = 8'h00; end
      11: begin fetch_if.attr_valid = 1'b1; fetch_if.attr_data = 2'd1; end
      17: begin fetch_if.plane_valid = 1'b1; fetch_if.plane_sel = 1'b0; fetch_if.plane_data = 8'hF0; end
      24: begin fetch_if.plane_valid = 1'b1; fetch_if.plane_sel = 1'b1; fetch_if.plane_data = 8'h81; end
      default: ;
    endcase
  endtask

  // Pixel at bit 15 after enabled tick m (tick 1 = first tick after reset).
  function automatic logic [7:0] base_px(input int m);
    if (m >= 16 && m <= 23) return tile1_px[m-16];
    if (m >= 24 && m <= 31) return 8'h05;
    if (m >= 32 && m <= 39) return tile3_px[m-32];
    if (m >= 40 && m <= 47) return tile4_px[m-40];
    return 8'h00;
  endfunction

  task automatic run_seq(input int fine, input int last_n, input bit pause);
    do_reset();
    enable            = 1'b1;
    backgroundDraw_EN = 1'b1;
    fineScroll        = 3'(fine);
    for (int n = 1; n <= last_n; n++) begin
      if (pause && n == 19) begin
        clear_fetch();
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
          tick();
          check("pause_px", 8'(pixelIndex), 8'h00);
          check("pause_phase", 8'(phase), 8'h02);
        end
        enable = 1'b1;
      end
      drive_n(n);
      tick();
      check($sformatf("px_f%0d_n%0d", fine, n), 8'(pixelIndex), base_px(n + fine));
      check($sformatf("phase_n%0d", n), 8'(phase), 8'(n % 8));
      if (n == 23) check("underrun_clear", 8'(tile_underrun), 8'h00);
      if (n == 24 || n == 47) check($sformatf("underrun_n%0d", n), 8'(tile_underrun), 8'h01);
    end
    clear_fetch();
  endtask

  initial begin
    bg_pixel_t full_px;
    logic [7:0] clip_exp;

    // Fine 0 with a 5-tick enable pause, partial staging and a capture on a reload tick.
    run_seq(0, 47, 1'b1);

    backgroundDraw_EN = 1'b0;
    #1;
    check("bgdraw_off", 8'(pixelIndex), 8'h00);
    backgroundDraw_EN = 1'b1;
    clock_EN = 1'b0;
    tick();
    tick();
    tick();
    check("clken_hold_phase", 8'(phase), 8'h07);
    check("clken_hold_px", 8'(pixelIndex), 8'h02);
    clock_EN = 1'b1;

    // Same stream with fineScroll=3 appears three ticks earlier.
    run_seq(3, 20, 1'b0);

    // Left-column clipping after line_start with fully lit tiles.
    do_reset();
    enable            = 1'b1;
    backgroundDraw_EN = 1'b1;
    full_px = '{bg_sel: 1'b0, attr: 2'b11, planes: 2'b11};
    fetch_if.attr_valid = 1'b1;
    fetch_if.attr_data  = 2'd3;
    fetch_if.plane_valid = 1'b1;
    fetch_if.plane_data  = 8'hFF;
    for (int n = 1; n <= 16; n++) begin
      fetch_if.plane_sel = 1'(n);
      tick();
    end
    check("pre_line_px", 8'(pixelIndex), 8'(full_px));
    line_start = 1'b1;
    clip_left  = 1'b1;
    fetch_if.plane_sel = 1'b1;
    tick();
    line_start = 1'b0;
    check("line_phase", 8'(phase), 8'h00);
    for (int k = 0; k <= 8; k++) begin
`ifdef BG_LEFT_CLIP_EN
      clip_exp = (k < 8) ? 8'h00 : 8'(full_px);
`else
      clip_exp = 8'(full_px);
`endif
      check($sformatf("clip_px%0d", k + 1), 8'(pixelIndex), clip_exp);
      if (k < 8) begin
        fetch_if.plane_sel = 1'(k);
        tick();
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
